// File: rtl/serial_word_collector_pkg.sv
// serial_word_collector_pkg: shared state encoding and default sizes for the serial word collector.
package serial_collector_pkg;
    typedef enum logic {COLLECT, PARITY} state_t;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;
endpackage

// File: rtl/serial_word_collector_bit_counter.sv
// collector_bit_counter: counts sampled bits, wraps after WIDTH-1 and flags the last bit of a word.
module collector_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last_bit
);
    assign last_bit = count == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (en) count <= last_bit ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: reassembles an LSB-first serial stream into words on a valid/ready port.
// Optional macro SERIAL_WORD_COLLECTOR_PARITY_EN appends an even-parity bit to each frame.
module serial_word_collector
    import serial_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    ,
    output logic             parity_err
`endif
);
    logic             last_bit, cnt_en, complete;
    logic [WIDTH-1:0] word;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    // The data word is fully shifted in before the parity cycle completes the frame.
    assign word     = shift_reg;
    assign cnt_en   = ser_en & (state == COLLECT);
    assign complete = ser_en & (state == PARITY);
`else
    // Only WIDTH-1 bits need storing: the final bit is taken straight from ser_in.
    logic [WIDTH-2:0] shift_reg;
    assign word     = {ser_in, shift_reg};
    assign cnt_en   = ser_en;
    assign complete = ser_en & last_bit;
`endif

    collector_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (cnt_en),
        .count   (bit_count),
        .last_bit(last_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
            state      <= COLLECT;
            parity_err <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
            if (cnt_en) shift_reg <= {ser_in, shift_reg[WIDTH-1:1]};
            if (cnt_en && last_bit) state <= PARITY;
            else if (complete) state <= COLLECT;
`else
            if (ser_en) shift_reg <= word[WIDTH-1:1];
`endif
            if (complete && (!out_valid || out_ready)) begin
                out_data   <= word;
                out_valid  <= 1'b1;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
                parity_err <= ^{word, ser_in};
`endif
            end else if (complete) overrun <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: table vectors, directed corner sequences and a random run against a frame-level model.
module tb_serial_word_collector;
    localparam int W = 8;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 0, reset = 0, ser_in = 0, ser_en = 0, out_ready = 0;
    logic [W-1:0] out_data;
    logic         out_valid, overrun;
    logic [3:0]   bit_count;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    logic         parity_err;
`endif

    int n_checks = 0, n_fail = 0;

    serial_word_collector dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_en(ser_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bit_count(bit_count), .overrun(overrun)
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Frame-level model: a list of received bits, turned into a word once a frame is full.
    int           q[$];
    logic [W-1:0] m_data = '0;
    bit           m_valid = 0, m_over = 0, m_perr = 0;

    task automatic model(input bit r, input bit en, input bit b, input bit rdy);
        logic [W-1:0] w;
        bit done, p;
        done = 0;
        if (r) begin
            q.delete();
            m_data = '0; m_valid = 0; m_over = 0; m_perr = 0;
        end else begin
            if (en) begin
                q.push_back(int'(b));
                if (q.size() == FRAME) begin
                    w = '0; p = 0;
                    for (int i = 0; i < W; i++) w[i] = q[i][0];
                    foreach (q[i]) p ^= q[i][0];
                    q.delete();
                    done = 1;
                end
            end
            if (done && (!m_valid || rdy)) begin
                m_data = w; m_valid = 1; m_perr = p;
            end else if (done) m_over = 1;
            else if (rdy) m_valid = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit b, input bit rdy);
        reset = r; ser_en = en; ser_in = b; out_ready = rdy;
        @(posedge clk);
        model(r, en, b, rdy);
        #1;
        check("model_valid", int'(out_valid), int'(m_valid));
        check("model_overrun", int'(overrun), int'(m_over));
        check("model_count", int'(bit_count), q.size() % W);
        if (m_valid) check("model_data", int'(out_data), int'(m_data));
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
        if (m_valid) check("model_perr", int'(parity_err), int'(m_perr));
`endif
    endtask

    typedef struct {
        logic r, en, b, rdy;
        logic [W-1:0] d;
        logic v;
        logic [3:0] c;
        logic o;
    } vec_t;
    vec_t tbl[19];

    initial begin
        logic [W-1:0] a5, c3, w;
        a5 = 8'hA5; c3 = 8'h3C;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tbl[1+i] = '{1'b0, 1'b1, a5[i], 1'b0, (i == 7) ? 8'hA5 : 8'h00, i == 7, 4'((i + 1) % 8), 1'b0};
            tbl[9+i] = '{1'b0, 1'b1, c3[i], 1'b0, 8'hA5, 1'b1, 4'((i + 1) % 8), i == 7};
        end
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b1};

`ifndef SERIAL_WORD_COLLECTOR_PARITY_EN
        // Words A5 then 3C with no consumer: second word is dropped, overrun sticks.
        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].en, tbl[k].b, tbl[k].rdy);
            check("tbl_data", int'(out_data), int'(tbl[k].d));
            check("tbl_valid", int'(out_valid), int'(tbl[k].v));
            check("tbl_count", int'(bit_count), int'(tbl[k].c));
            check("tbl_overrun", int'(overrun), int'(tbl[k].o));
        end
        cyc(1, 0, 0, 0);
        check("overrun_cleared_by_reset", int'(overrun), 0);

        // Back-to-back 01 and 80, accepted on the completion cycle of the second.
        w = 8'h01;
        for (int i = 0; i < 8; i++) cyc(0, 1, w[i], 0);
        check("b2b_first", int'(out_data), 8'h01);
        w = 8'h80;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, w[i], i == 7);
            check("b2b_valid_held", int'(out_valid), 1);
        end
        check("b2b_second", int'(out_data), 8'h80);
        check("b2b_no_overrun", int'(overrun), 0);
        cyc(0, 0, 0, 1);
        check("b2b_accept_clears", int'(out_valid), 0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check("midreset_count", int'(bit_count), 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0);
        check("midreset_data", int'(out_data), 8'hFF);
        check("midreset_valid", int'(out_valid), 1);

        // Gapped strobes: counter holds while ser_en is low.
        cyc(1, 0, 0, 0);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            int g;
            g = $urandom_range(3);
            for (int j = 0; j < g; j++) begin
                cyc(0, 0, 1, 0);
                check("gap_count_hold", int'(bit_count), i);
            end
            cyc(0, 1, w[i], 0);
        end
        check("gap_data", int'(out_data), 8'h5A);
        check("gap_valid", int'(out_valid), 1);
`else
        // A5 has even weight: parity bit 1 is an error, parity bit 0 is clean.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, a5[i], 0);
        check("par_not_yet_valid", int'(out_valid), 0);
        cyc(0, 1, 1, 0);
        check("par_valid", int'(out_valid), 1);
        check("par_err_set", int'(parity_err), 1);
        check("par_data", int'(out_data), 8'hA5);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, a5[i], 0);
        cyc(0, 1, 0, 0);
        check("par_err_clear", int'(parity_err), 0);
        check("par_valid2", int'(out_valid), 1);
`endif

        cyc(1, 0, 0, 0);
        for (int n = 0; n < 1500; n++)
            cyc($urandom_range(79) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                $urandom_range(2) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
